apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
//  Shares one APB master port among NUM_REQ requesters using round-robin arbitration.
//  Sequences each granted request through the APB SETUP/ACCESS phases and waits on PREADY.
//  Returns read data or error to the requester, and aborts stalled transfers with a timeout.
//  Sits between on-chip agents (DMA, CPU shim, debug) and the APB fabric feeding apb_if.slave_mp.
// PARAMETERS
//  NUM_REQ         4    number of requesters, >=2
//  APB_ADDR_WIDTH  16   PADDR width
//  APB_DATA_WIDTH  32   PWDATA/PRDATA width
//  TIMEOUT         256  max ACCESS cycles without PREADY before abort; 0 disables
// PORTS
//  PCLK       in   1               clock; all logic on posedge
//  PRESETn    in   1               asynchronous reset, active low
//  req_valid  in   NUM_REQ         per-requester transfer request
//  req_write  in   NUM_REQ         per-requester 1=write, 0=read
//  req_addr   in   NUM_REQ*AW      flattened addresses, slice i = [i*AW +: AW]
//  req_wdata  in   NUM_REQ*DW      flattened write data, slice i = [i*DW +: DW]
//  req_ready  out  NUM_REQ         one-hot; request i accepted this cycle
//  rsp_valid  out  NUM_REQ         one-hot 1-cycle pulse; transfer for i finished
//  rsp_rdata  out  DW              read data (0 for writes/timeouts), valid with rsp_valid
//  rsp_err    out  1               PSLVERR or timeout, valid with rsp_valid
//  PADDR/PWRITE/PWDATA/PSEL/PENABLE  out                        APB master outputs, registered
//  PREADY/PRDATA/PSLVERR             in  1/DW/1                 APB slave responses
// BEHAVIOUR
//  Reset (async, PRESETn=0):
//   - All registered outputs = 0; FSM=IDLE; rr_ptr=0; wait counter=0.
//   - Reset mid-transfer drops PSEL/PENABLE at once; no rsp_valid is issued for that transfer.
//  FSM IDLE -> SETUP -> ACCESS -> IDLE.
//  IDLE:
//   - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//   - req_ready[winner]=1 combinationally in IDLE only; handshake completes at that edge.
//   - At that edge: PADDR/PWRITE/PWDATA <= winner payload; owner <= winner; PSEL<=1; go SETUP.
//  SETUP:  one cycle, PSEL=1, PENABLE=0; next edge PENABLE<=1; go ACCESS; counter cleared.
//  ACCESS: PSEL=PENABLE=1; PADDR/PWRITE/PWDATA held stable.
//   - PREADY=1 at edge: PSEL<=0, PENABLE<=0, rsp_valid[owner]<=1 for 1 cycle.
//     rsp_rdata <= PWRITE?0:PRDATA; rsp_err <= PSLVERR;
//     rr_ptr <= (owner+1) mod NUM_REQ; go IDLE.
//   - PREADY=0: counter++. If TIMEOUT!=0 and counter reaches TIMEOUT:
//     same exit with rsp_err=1, rsp_rdata=0.
//   - Counter width = $clog2(TIMEOUT+1); counter never wraps.
//  Latency:
//   - req accepted at edge k -> PSEL high after k, PENABLE after k+1.
//   - Zero-wait response: rsp_valid high after k+2.
//   - Each wait state adds 1 cycle.
//   - Min 1 IDLE cycle between transfers; peak = 1 transfer per 3 cycles.
//  Requester rules:
//   - Hold req_valid and payload stable until req_ready.
//   - Only one outstanding transfer per requester.
//   - Dropping req_valid before grant is legal (request withdrawn).
//  Boundaries:
//   - req_valid=0 everywhere: stay IDLE, PSEL=0.
//   - rr_ptr wraps NUM_REQ-1 -> 0.
//   - req_valid changes outside IDLE are ignored until IDLE.
//   - PRDATA/PSLVERR are sampled only on the PREADY edge.
// TESTING
//  1. Req0 write 0x0010/0xDEADBEEF, PREADY=1 -> PSEL 2 cycles, PENABLE 1;
//     rsp_valid=0001 at k+2; rsp_err=0; rsp_rdata=0.
//  2. Req2 read 0x00A4, PREADY after 3 wait states, PRDATA=0x12345678
//     -> rsp_valid=0100 at k+5; rsp_rdata=0x12345678.
//  3. All 4 req_valid held high with back-to-back re-requests
//     -> grant order 0,1,2,3,0,1; each requester served once per 4 grants.
//  4. TIMEOUT=16, PREADY stuck 0 -> abort after 16 ACCESS cycles;
//     rsp_err=1; rsp_rdata=0; next request proceeds normally.
//  5. PREADY=1 with PSLVERR=1 on a read -> rsp_err=1; rsp_rdata=PRDATA; rr_ptr advances.
//  6. PRESETn low during ACCESS -> PSEL/PENABLE=0 immediately; no rsp_valid;
//     after release req3 pending is granted before higher indices only by scan from rr_ptr=0.

Source files
------------

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the arbiter (master side) and the APB fabric (slave side).
// Master drives address/control/write data; slave returns PREADY/PRDATA/PSLVERR.
interface apb_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PSEL;
  logic          PENABLE;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;

  modport master_mp (
    output PADDR, PWRITE, PWDATA, PSEL, PENABLE,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave_mp (
    input  PADDR, PWRITE, PWDATA, PSEL, PENABLE,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters,
// with SETUP/ACCESS sequencing, response return and an ACCESS-phase timeout.
//
// state     | meaning
// ST_IDLE   | no transfer; arbitrate, req_ready to the winner
// ST_SETUP  | PSEL=1, PENABLE=0 for one cycle
// ST_ACCESS | PSEL=PENABLE=1, wait for PREADY or timeout
module apb_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int APB_ADDR_WIDTH = 16,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 256
) (
  input  logic                               PCLK,
  input  logic                               PRESETn,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [APB_DATA_WIDTH-1:0]          rsp_rdata,
  output logic                               rsp_err,
  apb_if.master_mp                           apb
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                    r_state;
  logic [PW-1:0]             r_rr_ptr;
  logic [PW-1:0]             r_owner;
  logic [CW-1:0]             r_cnt;
  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic                      r_pwrite;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_psel;
  logic                      r_penable;
  logic [NUM_REQ-1:0]        r_rsp_valid;
  logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_err;

  logic                      w_found;
  logic [PW-1:0]             w_winner;
  logic [PW-1:0]             w_next_ptr;
  logic                      w_timeout_hit;
  logic [APB_ADDR_WIDTH-1:0] w_sel_addr;
  logic [APB_DATA_WIDTH-1:0] w_sel_wdata;

  // Scan starts at rr_ptr so the most recently served requester has lowest priority.
  always_comb begin
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = (int'(r_rr_ptr) + j) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = PW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == ST_IDLE && w_found) req_ready[w_winner] = 1'b1;
  end

  assign w_sel_addr    = req_addr[int'(w_winner)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
  assign w_sel_wdata   = req_wdata[int'(w_winner)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
  assign w_next_ptr    = (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
  // Fires on the edge that would complete the TIMEOUT-th stalled ACCESS cycle.
  assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_paddr  <= w_sel_addr;
            r_pwrite <= req_write[w_winner];
            r_pwdata <= w_sel_wdata;
            r_owner  <= w_winner;
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A late PREADY on the timeout edge still completes normally.
          if (apb.PREADY || w_timeout_hit) begin
            r_psel               <= 1'b0;
            r_penable            <= 1'b0;
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_rdata          <= (apb.PREADY && !r_pwrite) ? apb.PRDATA : '0;
            r_rsp_err            <= apb.PREADY ? apb.PSLVERR : 1'b1;
            r_rr_ptr             <= w_next_ptr;
            r_state              <= ST_IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign apb.PADDR   = r_paddr;
  assign apb.PWRITE  = r_pwrite;
  assign apb.PWDATA  = r_pwdata;
  assign apb.PSEL    = r_psel;
  assign apb.PENABLE = r_penable;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: a round-robin model plans grant order,
// APB and response monitors pop and compare independently of the stimulus.
module tb_apb_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  apb_if #(.AW(AW), .DW(DW)) apb ();

  apb_master_arbiter #(
    .NUM_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .PCLK(clk), .PRESETn(rst_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb(apb)
  );

  typedef struct {
    int            owner;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rdata;
    logic          err;
    int            waits;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            eff;
  } xfer_t;

  xfer_t stage_q[N][$];
  xfer_t pend_q[N][$];
  xfer_t exp_apb_q[$];
  xfer_t exp_rsp_q[$];
  xfer_t slave_q[$];
  int    setup_q[$];

  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  int       model_ptr = 0;
  logic [N-1:0] busy = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected by model (cycle %0d)", name, cyc);
  endtask

  function automatic xfer_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [DW-1:0] rd, input logic err, input int waits);
    xfer_t e;
    e.owner = 0; e.w = w; e.a = a; e.d = d; e.rdata = rd; e.err = err; e.waits = waits;
    e.exp_rdata = '0; e.exp_err = 1'b0; e.eff = 0;
    return e;
  endfunction

  // Requester agents: hold request until accepted, re-request only after own response.
  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    forever begin
      logic [N-1:0] hs, rv;
      xfer_t e;
      @(negedge clk);
      hs = req_ready;
      rv = rsp_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin req_valid[i] = 1'b0; busy[i] = 1'b1; end
        if (rv[i]) busy[i] = 1'b0;
        if (!req_valid[i] && !busy[i] && pend_q[i].size() > 0) begin
          e = pend_q[i].pop_front();
          req_write[i] = e.w;
          req_addr[i*AW +: AW] = e.a;
          req_wdata[i*DW +: DW] = e.d;
          req_valid[i] = 1'b1;
        end
      end
    end
  end

  // APB slave: PREADY after 'waits' stalled cycles; junk data/err while stalled.
  initial begin
    xfer_t s_cur;
    int    s_cnt;
    bit    s_active;
    s_active = 0; s_cnt = 0;
    s_cur = mk(0, '0, '0, '0, 0, 0);
    apb.PREADY = 1'b0; apb.PRDATA = '0; apb.PSLVERR = 1'b0;
    forever begin
      @(negedge clk);
      if (apb.PSEL && apb.PENABLE) begin
        if (!s_active) begin
          s_active = 1; s_cnt = 0;
          if (slave_q.size() == 0) begin
            fail("slave_unexpected_access");
            s_cur = mk(0, '0, '0, '0, 0, 0);
          end else s_cur = slave_q.pop_front();
        end
        if (s_cnt == s_cur.waits) begin
          apb.PREADY = 1'b1; apb.PRDATA = s_cur.rdata; apb.PSLVERR = s_cur.err;
        end else begin
          apb.PREADY = 1'b0; apb.PRDATA = $urandom; apb.PSLVERR = 1'($urandom_range(0, 1));
        end
        s_cnt++;
      end else begin
        s_active = 0; apb.PREADY = 1'b0; apb.PSLVERR = 1'b0; apb.PRDATA = $urandom;
      end
    end
  end

  // APB monitor: phase order, payload and stability.
  initial begin
    xfer_t m_cur;
    bit    m_have;
    logic  m_prev_psel;
    m_have = 0; m_prev_psel = 1'b0;
    m_cur = mk(0, '0, '0, '0, 0, 0);
    forever begin
      @(negedge clk);
      chk("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      if (apb.PSEL && !apb.PENABLE) begin
        if (exp_apb_q.size() == 0) fail("apb_unexpected_setup");
        else begin
          m_cur = exp_apb_q.pop_front();
          m_have = 1;
          chk("setup_paddr", 64'(apb.PADDR), 64'(m_cur.a));
          chk("setup_pwrite", 64'(apb.PWRITE), 64'(m_cur.w));
          chk("setup_pwdata", 64'(apb.PWDATA), 64'(m_cur.d));
          setup_q.push_back(cyc);
        end
      end else if (apb.PSEL && apb.PENABLE) begin
        chk("access_after_psel", 64'(m_prev_psel), 64'd1);
        if (m_have) begin
          chk("access_paddr_stable", 64'(apb.PADDR), 64'(m_cur.a));
          chk("access_pwdata_stable", 64'(apb.PWDATA), 64'(m_cur.d));
        end
      end else begin
        chk("penable_without_psel", 64'(apb.PENABLE), 64'd0);
      end
      m_prev_psel = apb.PSEL;
    end
  end

  // Response monitor: owner, data, error and latency from the SETUP cycle.
  initial begin
    xfer_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        if (exp_rsp_q.size() == 0) fail("rsp_unexpected");
        else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_valid_owner", 64'(rsp_valid), 64'd1 << e.owner);
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.exp_rdata));
          chk("rsp_err", 64'(rsp_err), 64'(e.exp_err));
          if (setup_q.size() == 0) fail("rsp_without_setup");
          else chk("rsp_latency", 64'(cyc), 64'(setup_q.pop_front() + 2 + e.eff));
        end
      end
    end
  end

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      pend_q[i].delete();
      stage_q[i].delete();
    end
    exp_apb_q.delete(); exp_rsp_q.delete(); slave_q.delete(); setup_q.delete();
    req_valid = '0;
    busy = '0;
  endtask

  // Reference model: round-robin over requesters that still have staged transfers.
  task automatic plan_and_load();
    int    rem[N];
    int    taken[N];
    int    total;
    bit    found;
    int    i;
    xfer_t e;
    total = 0;
    for (int r = 0; r < N; r++) begin
      rem[r] = stage_q[r].size(); taken[r] = 0; total += rem[r];
    end
    while (total > 0) begin
      found = 0;
      for (int j = 0; j < N; j++) begin
        i = (model_ptr + j) % N;
        if (!found && taken[i] < rem[i]) begin
          found = 1;
          e = stage_q[i][taken[i]];
          taken[i]++;
          e.owner = i;
          if (e.waits >= TO) begin
            e.exp_err = 1'b1; e.exp_rdata = '0; e.eff = TO - 1;
          end else begin
            e.exp_err = e.err; e.exp_rdata = e.w ? '0 : e.rdata; e.eff = e.waits;
          end
          exp_apb_q.push_back(e); slave_q.push_back(e); exp_rsp_q.push_back(e);
          model_ptr = (i + 1) % N;
          total--;
        end
      end
    end
    for (int r = 0; r < N; r++) begin
      while (stage_q[r].size() > 0) pend_q[r].push_back(stage_q[r].pop_front());
    end
  endtask

  task automatic run_batch();
    plan_and_load();
    for (int k = 0; k < 3000 && exp_rsp_q.size() > 0; k++) @(negedge clk);
    if (exp_rsp_q.size() > 0) begin
      chk("batch_drain_pending", 64'(exp_rsp_q.size()), 64'd0);
      flush();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit seen;
    repeat (3) @(negedge clk);
    chk("reset_psel", 64'(apb.PSEL), 64'd0);
    chk("reset_penable", 64'(apb.PENABLE), 64'd0);
    chk("reset_paddr", 64'(apb.PADDR), 64'd0);
    chk("reset_pwrite", 64'(apb.PWRITE), 64'd0);
    chk("reset_pwdata", 64'(apb.PWDATA), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_psel", 64'(apb.PSEL), 64'd0);
      chk("idle_req_ready", 64'(req_ready), 64'd0);
    end

    stage_q[0].push_back(mk(1, 16'h0010, 32'hDEADBEEF, 32'h0BADF00D, 0, 0));
    run_batch();
    stage_q[2].push_back(mk(0, 16'h00A4, 32'h0, 32'h12345678, 0, 3));
    run_batch();
    for (int i = 0; i < N; i++) begin
      stage_q[i].push_back(mk(1'($urandom_range(0, 1)), 16'(16'h100 + i), $urandom, $urandom, 0, 0));
      stage_q[i].push_back(mk(1'($urandom_range(0, 1)), 16'(16'h200 + i), $urandom, $urandom, 0, 0));
    end
    run_batch();
    stage_q[1].push_back(mk(0, 16'h0C00, 32'h0, 32'hCAFEF00D, 0, 40));
    run_batch();
    stage_q[1].push_back(mk(0, 16'h0C04, 32'h0, 32'h600DDA7A, 0, 1));
    run_batch();
    stage_q[3].push_back(mk(0, 16'h0E00, 32'h0, 32'hA5A55A5A, 1, 0));
    run_batch();
    stage_q[0].push_back(mk(1, 16'h0E04, 32'h11112222, 32'h0, 1, 2));
    stage_q[3].push_back(mk(0, 16'h0E08, 32'h0, 32'h33334444, 0, 0));
    run_batch();

    // Reset in the middle of an ACCESS phase.
    stage_q[2].push_back(mk(0, 16'h0BAD, 32'h0, 32'h1, 0, 50));
    plan_and_load();
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = apb.PSEL && apb.PENABLE;
    end
    if (!seen) fail("reset_test_no_access");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_psel", 64'(apb.PSEL), 64'd0);
    chk("async_reset_penable", 64'(apb.PENABLE), 64'd0);
    chk("async_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    flush();
    model_ptr = 0;
    repeat (2) begin
      @(negedge clk);
      chk("in_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    end
    #2 rst_n = 1'b1;
    stage_q[3].push_back(mk(0, 16'h0F03, 32'h0, 32'h03030303, 0, 0));
    stage_q[1].push_back(mk(1, 16'h0F01, 32'h01010101, 32'h0, 0, 1));
    run_batch();

    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < N; i++) begin
        int cnt;
        cnt = $urandom_range(0, 2);
        for (int t = 0; t < cnt; t++) begin
          int w;
          r = $urandom_range(0, 9);
          w = (r == 0) ? 20 : ((r < 4) ? $urandom_range(1, 4) : 0);
          stage_q[i].push_back(mk(1'($urandom_range(0, 1)), 16'($urandom), $urandom, $urandom,
                                  1'($urandom_range(0, 3) == 0), w));
        end
      end
      if (stage_q[0].size() + stage_q[1].size() + stage_q[2].size() + stage_q[3].size() == 0)
        stage_q[b % N].push_back(mk(0, 16'($urandom), $urandom, $urandom, 0, 0));
      run_batch();
    end

    chk("final_rsp_queue_empty", 64'(exp_rsp_q.size()), 64'd0);
    chk("final_apb_queue_empty", 64'(exp_apb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
